// File: rtl/nn_pkg.sv
// Shared constants and types for the layer-to-layer datapath.
package nn_pkg;

  localparam int unsigned DEFAULT_DATAWIDTH = 16;

  localparam int unsigned LAYER1_NEURONS = 32;
  localparam int unsigned LAYER2_NEURONS = 16;
  localparam int unsigned LAYER3_NEURONS = 10;

  typedef enum logic {IDLE, SEND} ser_state_t;

endpackage

// File: rtl/layer_ser_argmax.sv
// Streaming signed max/index tracker over one serialized frame.
// Seeded by the word flagged 'first'; result registered the cycle after 'last'.
module layer_ser_argmax #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned IDXWIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] word,
  input  logic                 valid,
  input  logic                 first,
  input  logic                 last,
  output logic [IDXWIDTH-1:0]  idx,
  output logic                 idx_valid
);

  logic signed [DATAWIDTH-1:0] max_q;
  logic [IDXWIDTH-1:0]         max_idx_q;
  logic [IDXWIDTH-1:0]         cnt_q;
  logic [IDXWIDTH-1:0]         cur_idx;
  logic [IDXWIDTH-1:0]         best_idx;
  logic                        take;

  assign cur_idx  = first ? '0 : cnt_q;
  // Strict compare so ties keep the earlier (lower) index.
  assign take     = first || ($signed(word) > max_q);
  assign best_idx = take ? cur_idx : max_idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_q     <= '0;
      max_idx_q <= '0;
      cnt_q     <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
    end else begin
      idx_valid <= 1'b0;
      if (valid) begin
        if (take) begin
          max_q     <= $signed(word);
          max_idx_q <= cur_idx;
        end
        cnt_q <= cur_idx + 1'b1;
        if (last) begin
          idx       <= best_idx;
          idx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/layer_output_serializer.sv
// Captures a full layer output vector and replays it one word per cycle, with a
// one-deep shadow buffer. Optional classifier argmax under LAYER_SER_ARGMAX_EN.
module layer_output_serializer
  import nn_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = LAYER3_NEURONS,
  parameter int unsigned DATAWIDTH   = DEFAULT_DATAWIDTH,
  parameter int unsigned IDXWIDTH    = $clog2(NUM_NEURONS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_NEURONS*DATAWIDTH-1:0] x_in,
  input  logic [NUM_NEURONS-1:0]           o_valid_in,
  output logic [DATAWIDTH-1:0]             input_val,
  output logic                             input_valid,
  output logic                             frame_last,
  output logic                             busy,
  output logic                             overrun,
  output logic [IDXWIDTH-1:0]              argmax_idx,
  output logic                             argmax_valid
);

  localparam int unsigned         VecW    = NUM_NEURONS * DATAWIDTH;
  localparam logic [IDXWIDTH-1:0] LastIdx = IDXWIDTH'(NUM_NEURONS - 1);

  ser_state_t          state_q;
  logic [IDXWIDTH-1:0] idx_q;
  logic [IDXWIDTH-1:0] idx_next;
  logic [VecW-1:0]     active_q;
  logic [VecW-1:0]     shadow_q;
  logic                shadow_full_q;
  logic                capture;

  assign capture  = &o_valid_in;
  assign idx_next = idx_q + 1'b1;
  assign busy     = (state_q == SEND) || shadow_full_q;

  // idx_q is the index of the word currently presented on input_val.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      active_q      <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      overrun       <= 1'b0;
      input_val     <= '0;
      input_valid   <= 1'b0;
      frame_last    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (capture) begin
            state_q     <= SEND;
            idx_q       <= '0;
            active_q    <= x_in;
            input_val   <= x_in[DATAWIDTH-1:0];
            input_valid <= 1'b1;
            frame_last  <= 1'b0;
          end
        end
        SEND: begin
          if (idx_q != LastIdx) begin
            idx_q      <= idx_next;
            input_val  <= active_q[idx_next*DATAWIDTH +: DATAWIDTH];
            frame_last <= (idx_next == LastIdx);
            if (capture) begin
              if (!shadow_full_q) begin
                shadow_q      <= x_in;
                shadow_full_q <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else begin
            idx_q      <= '0;
            frame_last <= 1'b0;
            if (shadow_full_q) begin
              active_q  <= shadow_q;
              input_val <= shadow_q[DATAWIDTH-1:0];
              // The shadow is freed this cycle, so a coincident vector refills it.
              if (capture) shadow_q <= x_in;
              else         shadow_full_q <= 1'b0;
            end else if (capture) begin
              active_q  <= x_in;
              input_val <= x_in[DATAWIDTH-1:0];
            end else begin
              state_q     <= IDLE;
              input_val   <= '0;
              input_valid <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LAYER_SER_ARGMAX_EN
  logic first_word;
  assign first_word = input_valid && (idx_q == '0);

  layer_ser_argmax #(
    .DATAWIDTH (DATAWIDTH),
    .IDXWIDTH  (IDXWIDTH)
  ) u_argmax (
    .clk       (clk),
    .rst       (rst),
    .word      (input_val),
    .valid     (input_valid),
    .first     (first_word),
    .last      (frame_last),
    .idx       (argmax_idx),
    .idx_valid (argmax_valid)
  );
`else
  assign argmax_idx   = '0;
  assign argmax_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_output_serializer.sv
// Scoreboard bench for layer_output_serializer; argmax checks follow LAYER_SER_ARGMAX_EN.
module tb_layer_output_serializer;

  localparam int unsigned N  = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 4;
  localparam int unsigned VW = N * DW;

  logic          clk;
  logic          rst;
  logic [VW-1:0] x_in;
  logic [N-1:0]  o_valid_in;
  logic [DW-1:0] input_val;
  logic          input_valid;
  logic          frame_last;
  logic          busy;
  logic          overrun;
  logic [IW-1:0] argmax_idx;
  logic          argmax_valid;

  typedef struct {
    logic [DW-1:0] val;
    logic          last;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   argmax_pulses;

  layer_output_serializer #(
    .NUM_NEURONS (N),
    .DATAWIDTH   (DW),
    .IDXWIDTH    (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .x_in         (x_in),
    .o_valid_in   (o_valid_in),
    .input_val    (input_val),
    .input_valid  (input_valid),
    .frame_last   (frame_last),
    .busy         (busy),
    .overrun      (overrun),
    .argmax_idx   (argmax_idx),
    .argmax_valid (argmax_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: every presented word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && argmax_valid) argmax_pulses++;
    if (rst && input_valid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_word", 32'(input_val), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("word_val", 32'(input_val), 32'(e.val));
        check_eq("word_last", 32'(frame_last), 32'(e.last));
        check_eq("word_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  function automatic logic [VW-1:0] make_vec(input logic [DW-1:0] base, input logic [DW-1:0] step);
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = base + DW'(k) * step;
    return v;
  endfunction

  task automatic push_frame(input logic [VW-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      exp_t e;
      e.val  = v[k*DW +: DW];
      e.last = (k == N - 1);
      e.cyc  = start + k;
      sb.push_back(e);
    end
  endtask

  // Called #1 after a rising edge; holds the pattern during cycle 'at' only.
  task automatic drive_at(input int at, input logic [VW-1:0] v, input logic [N-1:0] vbits);
    while (cyc < at) begin
      @(posedge clk);
      #1;
    end
    x_in       = v;
    o_valid_in = vbits;
    @(posedge clk);
    #1;
    o_valid_in = '0;
  endtask

  task automatic wait_cycle(input int at);
    while (cyc < at) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [VW-1:0] va, vb, vc, vam;
  int            b;
  int            best;
  logic signed [DW-1:0] am_words [N];

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    argmax_pulses = 0;
    x_in          = '0;
    o_valid_in    = '0;
    rst           = 1'b0;
    #2;
    check_eq("rst_valid", 32'(input_valid), 32'd0);
    check_eq("rst_last", 32'(frame_last), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_val", 32'(input_val), 32'd0);
    apply_reset();

    // Frame, mid-frame shadow fill, then a dropped third vector.
    va = make_vec(16'h0000, 16'h0100);
    vb = make_vec(16'hA000, 16'h0001);
    vc = make_vec(16'hC000, 16'h0001);
    b  = cyc + 2;
    push_frame(va, b + 1);
    push_frame(vb, b + 11);
    drive_at(b, va, '1);
    drive_at(b + 3, vb, '1);
    drive_at(b + 5, vc, '1);
    check_eq("overrun_set", 32'(overrun), 32'd1);
    wait_cycle(b + 20);
    @(negedge clk);
    check_eq("busy_on_last", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("busy_after", 32'(busy), 32'd0);
    check_eq("idle_val_zero", 32'(input_val), 32'd0);
    check_eq("idle_last_zero", 32'(frame_last), 32'd0);
    check_eq("overrun_sticky", 32'(overrun), 32'd1);
    wait_drain(10);

    // Capture coincident with frame_last, then a partial valid in IDLE.
    apply_reset();
    check_eq("overrun_cleared", 32'(overrun), 32'd0);
    va = make_vec(16'h1000, 16'h0011);
    vb = make_vec(16'h2000, 16'h0022);
    b  = cyc + 1;
    push_frame(va, b + 1);
    push_frame(vb, b + 11);
    drive_at(b, va, '1);
    drive_at(b + 10, vb, '1);
    wait_drain(30);
    @(posedge clk);
    #1;
    drive_at(cyc + 1, make_vec(16'h3000, 16'h0001), 10'h3FE);
    @(negedge clk);
    check_eq("partial_busy", 32'(busy), 32'd0);
    check_eq("partial_valid", 32'(input_valid), 32'd0);
    check_eq("no_overrun", 32'(overrun), 32'd0);

    // Asynchronous reset mid-frame with overrun already set.
    b = cyc + 1;
    push_frame(va, b + 1);
    drive_at(b, va, '1);
    drive_at(b + 2, vb, '1);
    drive_at(b + 4, vc, '1);
    check_eq("pre_rst_overrun", 32'(overrun), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_eq("async_valid", 32'(input_valid), 32'd0);
    check_eq("async_last", 32'(frame_last), 32'd0);
    check_eq("async_busy", 32'(busy), 32'd0);
    check_eq("async_overrun", 32'(overrun), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    b = cyc + 1;
    push_frame(vc, b + 1);
    drive_at(b, vc, '1);
    wait_drain(30);

    // Classifier frame: max 7 occurs at indices 2 and 3; the lower index wins.
    am_words = '{-16'sd5, 16'sd3, 16'sd7, 16'sd7, -16'sd1, 16'sd0, 16'sd2, 16'sd1, 16'sd6, 16'sd4};
    for (int k = 0; k < N; k++) vam[k*DW +: DW] = am_words[k];
    best = 0;
    for (int k = 1; k < N; k++) if (am_words[k] > am_words[best]) best = k;
    b = cyc + 1;
    push_frame(vam, b + 1);
    drive_at(b, vam, '1);
    wait_cycle(b + 10);
    @(negedge clk);
    check_eq("am_frame_last", 32'(frame_last), 32'd1);
    @(negedge clk);
`ifdef LAYER_SER_ARGMAX_EN
    check_eq("argmax_pulse", 32'(argmax_valid), 32'd1);
    check_eq("argmax_idx", 32'(argmax_idx), 32'(best));
    @(negedge clk);
    check_eq("argmax_one_cycle", 32'(argmax_valid), 32'd0);
`else
    check_eq("argmax_never", 32'(argmax_pulses), 32'd0);
    check_eq("argmax_idx_tied", 32'(argmax_idx), 32'd0);
`endif
    wait_drain(10);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
